uart_cmd_bridge: RTL
====================

# uart_cmd_bridge

Byte-level command bridge between the UART receiver/transmitter and `sdram_ctrl`. It parses multi-byte host commands into full-width SDRAM write and read requests: a 22-bit address and 16-bit data, where the current single-byte scheme only reaches 8 bits. It returns read data and status bytes to the host. It sits downstream of `uart` RX, upstream of `sdram_ctrl` request ports, and upstream of `uart` TX.

## Interface
- `IAddrWidth`, 22: SDRAM request address width. Framing is fixed at 3 address bytes.
- `DataWidth`, 16: SDRAM data width. Framing is fixed at 2 data bytes.
- `ByteTimeout`, 1_330_000: maximum idle cycles between bytes inside a command (10 ms at 133 MHz).
- `RdTimeout`, 1024: maximum cycles from `o_rd_req` to `i_rd_rdy`.

Ports:
- `i_sys_clk`  in  1  single clock, rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_rx_data`  in  8  received byte, valid while `i_rx_rdy`.
- `i_rx_rdy`  in  1  UART has a byte.
- `o_rx_req`  out  1  one-cycle pop of the current RX byte.
- `o_tx_data`  out  8  byte to send, valid with `o_tx_req`.
- `o_tx_req`  out  1  one-cycle send request.
- `i_tx_rdy`  in  1  UART TX idle.
- `o_wr_req`  out  1  one-cycle SDRAM write request.
- `o_wr_addr`  out  IAddrWidth  write address.
- `o_wr_data`  out  DataWidth  write data.
- `o_rd_req`  out  1  one-cycle SDRAM read request.
- `o_rd_addr`  out  IAddrWidth  read address.
- `i_rd_data`  in  DataWidth  read data, valid with `i_rd_rdy`.
- `i_rd_rdy`  in  1  read data strobe.

## Operation
- **Write frame:** 0x77 ('w'), A2, A1, A0, D1, D0, all big-endian.
  - The address is {A2,A1,A0}[21:0]; A2[7:6] are ignored.
  - After D0: pulse `o_wr_req`, then send 0x6B ('k').
- **Read frame:** 0x72 ('r'), A2, A1, A0.
  - After A0: pulse `o_rd_req`, wait for `i_rd_rdy`, capture `i_rd_data`.
  - Send data[15:8], then data[7:0].
- **Any other command byte:** send 0x3F ('?') and return to IDLE.
- **Inter-byte timeout:** a cycle counter runs in GET_ADDR/GET_DATA and resets on every accepted byte. When it reaches `ByteTimeout`, abort the frame, send 0x21 ('!') and return to IDLE. No SDRAM request is issued.
- **Read timeout:** a counter runs in WAIT_RD. When it reaches `RdTimeout`, send 0x21 and return to IDLE.
- **States:** IDLE → (byte accepted) DECODE → GET_ADDR (3 bytes) → [write] GET_DATA (2 bytes) → ISSUE_WR → SEND; [read] ISSUE_RD → WAIT_RD → SEND; DECODE(invalid)/timeout → SEND. SEND → IDLE after the last queued byte is requested.
- **RX handshake:** a byte is accepted in a cycle where `i_rx_rdy`=1, `o_rx_req` was 0 the previous cycle, and state ∈ {IDLE, GET_ADDR, GET_DATA}.
  - `i_rx_data` is captured at that edge and `o_rx_req` is high for the following cycle.
  - `o_rx_req` is never high on two consecutive cycles.
- **RX outside those states:** bytes are not consumed in DECODE, ISSUE_*, WAIT_RD or SEND; they stay in the UART.
- **TX handshake:** `o_tx_req` is asserted for one cycle when `i_tx_rdy`=1 and `o_tx_req` was 0 the previous cycle. `o_tx_data` is valid only in the `o_tx_req` cycle and is 0 otherwise.
- **Stray read data:** `i_rd_rdy` outside WAIT_RD is ignored.
- **Output hold:** `o_wr_addr`/`o_wr_data`/`o_rd_addr` update only in ISSUE_WR/ISSUE_RD and hold until the next issue of the same type.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Reset is asynchronous and takes effect mid-frame; partial frames and queued responses are discarded, and no request pulse appears during or after reset.
- **Write latency:** if D0 is accepted at edge m, `o_wr_req`=1 during cycle m+1. 'k' is requested at the earliest edge ≥ m+2 with `i_tx_rdy`=1.
- **Read latency:** if A0 is accepted at edge m, `o_rd_req`=1 during cycle m+1.
  - `i_rd_rdy` sampled at edge k: the high byte is requested at the earliest edge ≥ k+1 with `i_tx_rdy`.
  - The low byte is requested at the earliest edge with `i_tx_rdy` that is at least 2 cycles after the high-byte request.
- **Request width:** `o_wr_req` and `o_rd_req` are exactly 1 cycle. They are never asserted together.
- **Read-timeout boundary:** the timeout fires when the count equals `RdTimeout`. If `i_rd_rdy` arrives in that same cycle, the data wins.
- **Byte-timeout boundary:** when a byte is accepted in the same cycle the byte timeout expires, the byte wins.

## Test plan
- **Write:** 'w',00,12,34,AB,CD → one `o_wr_req` pulse with addr 0x001234 and data 0xABCD, then TX 0x6B.
- **Read:** 'r',3F,FF,FF → `o_rd_req` with addr 0x3FFFFF; drive `i_rd_data`=0xBEEF → TX 0xBE then 0xEF in order, respecting `i_tx_rdy` stalls.
- **Invalid and masked address:** 0x41 → TX 0x3F with no requests. 'w',C0,00,01,00,05 → addr 0x000001, bits [7:6] dropped.
- **Timeouts:** 'w',00,00 then silence for `ByteTimeout` → TX 0x21, no `o_wr_req`. 'r' with `i_rd_rdy` withheld → TX 0x21 after `RdTimeout`.
- **Back-to-back RX:** hold `i_rx_rdy`=1 continuously → `o_rx_req` never high on two consecutive cycles. Bytes sent during WAIT_RD are not popped until IDLE.
- **Reset mid-frame:** assert `i_rst` mid-frame after 'w',00,00 → all outputs are 0 at once; a subsequent valid read frame works normally.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// Host command bridge: parses 'w'/'r' UART frames into full-width SDRAM
// write/read requests and returns an ack, the read data or an error byte.
module uart_cmd_bridge #(
   parameter int unsigned IAddrWidth  = 22,
   parameter int unsigned DataWidth   = 16,
   parameter int unsigned ByteTimeout = 1_330_000,
   parameter int unsigned RdTimeout   = 1024
) (
   input  logic                  i_sys_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_rdy,
   output logic                  o_rx_req,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_req,
   input  logic                  i_tx_rdy,
   output logic                  o_wr_req,
   output logic [IAddrWidth-1:0] o_wr_addr,
   output logic [DataWidth-1:0]  o_wr_data,
   output logic                  o_rd_req,
   output logic [IAddrWidth-1:0] o_rd_addr,
   input  logic [DataWidth-1:0]  i_rd_data,
   input  logic                  i_rd_rdy
);

   localparam int unsigned BtoWidth = $clog2(ByteTimeout + 1);
   localparam int unsigned RtoWidth = $clog2(RdTimeout + 1);
   localparam logic [7:0]  CmdWr    = 8'h77;
   localparam logic [7:0]  CmdRd    = 8'h72;
   localparam logic [7:0]  RspOk    = 8'h6B;
   localparam logic [7:0]  RspBad   = 8'h3F;
   localparam logic [7:0]  RspErr   = 8'h21;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_GET_ADDR, S_GET_DATA,
      S_ISSUE_WR, S_ISSUE_RD, S_WAIT_RD, S_SEND
   } state_t;

   state_t                  state;
   logic [7:0]              cmd;
   logic [15:0]             addr_sr;
   logic [IAddrWidth-1:0]   addr_q;
   logic [7:0]              data_hi;
   logic [1:0]              byte_cnt;
   logic [BtoWidth-1:0]     byte_tmr;
   logic [RtoWidth-1:0]     rd_tmr;
   logic [7:0]              tx_hi;
   logic [7:0]              tx_lo;
   logic                    tx_two;

   logic                    rx_accept_c;
   logic [23:0]             addr_full_c;
   logic [15:0]             rd_word_c;

   // A byte is only popped where the parser can use it, never on back-to-back cycles.
   assign rx_accept_c = i_rx_rdy && !o_rx_req &&
                        (state == S_IDLE || state == S_GET_ADDR || state == S_GET_DATA);
   assign addr_full_c = {addr_sr, i_rx_data};
   assign rd_word_c   = 16'(i_rd_data);

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cmd       <= '0;
         addr_sr   <= '0;
         addr_q    <= '0;
         data_hi   <= '0;
         byte_cnt  <= '0;
         byte_tmr  <= '0;
         rd_tmr    <= '0;
         tx_hi     <= '0;
         tx_lo     <= '0;
         tx_two    <= 1'b0;
         o_rx_req  <= 1'b0;
         o_tx_req  <= 1'b0;
         o_tx_data <= '0;
         o_wr_req  <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_rd_req  <= 1'b0;
         o_rd_addr <= '0;
      end else begin
         o_rx_req  <= rx_accept_c;
         o_tx_req  <= 1'b0;
         o_tx_data <= '0;
         o_wr_req  <= 1'b0;
         o_rd_req  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_accept_c) begin
                  cmd   <= i_rx_data;
                  state <= S_DECODE;
               end
            end

            S_DECODE: begin
               byte_cnt <= '0;
               byte_tmr <= '0;
               if (cmd == CmdWr || cmd == CmdRd) begin
                  state <= S_GET_ADDR;
               end else begin
                  tx_hi  <= RspBad;
                  tx_two <= 1'b0;
                  state  <= S_SEND;
               end
            end

            // An accepted byte takes priority over a timer expiring in the same cycle.
            S_GET_ADDR: begin
               if (rx_accept_c) begin
                  addr_sr  <= {addr_sr[7:0], i_rx_data};
                  byte_tmr <= '0;
                  if (byte_cnt == 2'd2) begin
                     byte_cnt <= '0;
                     addr_q   <= IAddrWidth'(addr_full_c);
                     if (cmd == CmdWr) begin
                        state <= S_GET_DATA;
                     end else begin
                        o_rd_req  <= 1'b1;
                        o_rd_addr <= IAddrWidth'(addr_full_c);
                        state     <= S_ISSUE_RD;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end else if (byte_tmr == BtoWidth'(ByteTimeout)) begin
                  tx_hi  <= RspErr;
                  tx_two <= 1'b0;
                  state  <= S_SEND;
               end else begin
                  byte_tmr <= byte_tmr + BtoWidth'(1);
               end
            end

            S_GET_DATA: begin
               if (rx_accept_c) begin
                  byte_tmr <= '0;
                  if (byte_cnt == 2'd1) begin
                     o_wr_req  <= 1'b1;
                     o_wr_addr <= addr_q;
                     o_wr_data <= DataWidth'({data_hi, i_rx_data});
                     state     <= S_ISSUE_WR;
                  end else begin
                     data_hi  <= i_rx_data;
                     byte_cnt <= 2'd1;
                  end
               end else if (byte_tmr == BtoWidth'(ByteTimeout)) begin
                  tx_hi  <= RspErr;
                  tx_two <= 1'b0;
                  state  <= S_SEND;
               end else begin
                  byte_tmr <= byte_tmr + BtoWidth'(1);
               end
            end

            S_ISSUE_WR: begin
               tx_hi  <= RspOk;
               tx_two <= 1'b0;
               state  <= S_SEND;
            end

            S_ISSUE_RD: begin
               rd_tmr <= '0;
               state  <= S_WAIT_RD;
            end

            // Read data arriving on the expiry cycle still wins over the timeout.
            S_WAIT_RD: begin
               if (i_rd_rdy) begin
                  tx_hi  <= rd_word_c[15:8];
                  tx_lo  <= rd_word_c[7:0];
                  tx_two <= 1'b1;
                  state  <= S_SEND;
               end else if (rd_tmr == RtoWidth'(RdTimeout)) begin
                  tx_hi  <= RspErr;
                  tx_two <= 1'b0;
                  state  <= S_SEND;
               end else begin
                  rd_tmr <= rd_tmr + RtoWidth'(1);
               end
            end

            S_SEND: begin
               if (i_tx_rdy && !o_tx_req) begin
                  o_tx_req  <= 1'b1;
                  o_tx_data <= tx_hi;
                  if (tx_two) begin
                     tx_hi  <= tx_lo;
                     tx_two <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
